// File: rtl/paula_floppy_deserializer_if.sv
// Drive-side bitstream, DSKSYNC/ADKCON controls and FIFO/DSKBYTR outputs of the disk-read deserializer.
// The master is the drive model / register side; the slave is the deserializer.
interface paula_floppy_deserializer_if;
    logic        clk7_en;
    logic        bit_valid;
    logic        bit_in;
    logic        dma_en;
    logic        wordsync_en;
    logic [15:0] dsksync;
    logic        fifo_full;
    logic [15:0] fifo_data;
    logic        fifo_wr;
    logic        sync_det;
    logic        overflow;
    logic [7:0]  byte_data;
    logic        byte_ready;

    modport master (
        output clk7_en, bit_valid, bit_in, dma_en, wordsync_en, dsksync, fifo_full,
        input  fifo_data, fifo_wr, sync_det, overflow, byte_data, byte_ready
    );

    modport slave (
        input  clk7_en, bit_valid, bit_in, dma_en, wordsync_en, dsksync, fifo_full,
        output fifo_data, fifo_wr, sync_det, overflow, byte_data, byte_ready
    );
endinterface

// File: rtl/paula_floppy_deserializer.sv
// MFM bit deserializer: DSKSYNC hunt, 16-bit word assembly into the floppy FIFO, DSKBYTR byte view.
// All outputs registered, one enabled cycle after the completing bit; full FIFO drops the word and sets overflow.
module paula_floppy_deserializer (
    input  logic clk,
    input  logic reset_n,
    paula_floppy_deserializer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HUNT     = 2'd1,
        ASSEMBLE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_sr;
    logic [3:0]  r_bcnt;
    logic [15:0] r_fifo_data;
    logic        r_fifo_wr;
    logic        r_sync_det;
    logic        r_overflow;
    logic [7:0]  r_byte_data;
    logic        r_byte_ready;

    logic [15:0] w_nsr;
    logic        w_match;
    logic        w_realign;
    logic        w_byte_done;
    logic        w_word_done;

    always_comb begin
        w_nsr       = {r_sr[14:0], bus.bit_in};
        w_match     = bus.bit_valid && (w_nsr == bus.dsksync);
        // Only a sync seen with WORDSYNC set moves the word/byte boundary.
        w_realign   = w_match && bus.wordsync_en;
        w_byte_done = bus.bit_valid && ((r_bcnt[2:0] == 3'd7) || w_realign);
        w_word_done = bus.bit_valid && ((r_bcnt == 4'd15) || w_realign);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sr         <= 16'h0000;
            r_bcnt       <= 4'd0;
            r_fifo_data  <= 16'h0000;
            r_fifo_wr    <= 1'b0;
            r_sync_det   <= 1'b0;
            r_overflow   <= 1'b0;
            r_byte_data  <= 8'h00;
            r_byte_ready <= 1'b0;
        end else if (bus.clk7_en) begin
            r_fifo_wr    <= 1'b0;
            r_sync_det   <= w_match;
            r_byte_ready <= w_byte_done;

            if (bus.bit_valid) begin
                r_sr   <= w_nsr;
                r_bcnt <= w_realign ? 4'd0 : r_bcnt + 4'd1;
            end

            if (w_byte_done) begin
                r_byte_data <= w_nsr[7:0];
            end

            if (!bus.dma_en) begin
                r_state    <= IDLE;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.wordsync_en) begin
                            r_state <= HUNT;
                        end else begin
                            // Free-running mode: the next bit is bit 15 of the first word.
                            r_state <= ASSEMBLE;
                            r_bcnt  <= 4'd0;
                        end
                    end
                    HUNT: begin
                        if (w_match) begin
                            r_state <= ASSEMBLE;
                        end
                    end
                    ASSEMBLE: begin
                        if (w_word_done) begin
                            r_fifo_data <= w_nsr;
                            if (bus.fifo_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_fifo_wr <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.fifo_data  = r_fifo_data;
    assign bus.fifo_wr    = r_fifo_wr;
    assign bus.sync_det   = r_sync_det;
    assign bus.overflow   = r_overflow;
    assign bus.byte_data  = r_byte_data;
    assign bus.byte_ready = r_byte_ready;
endmodule

// File: doc/paula_floppy_deserializer.md
# paula_floppy_deserializer

Disk-read front end of Paula's floppy path. Takes the serial MFM bitstream from the drive model one bit per strobe, searches for the DSKSYNC pattern when word-sync is enabled, and assembles 16-bit words. It writes each word into the downstream floppy FIFO with a single-cycle write strobe. It also provides the byte-level view used by DSKBYTR, raises the DSKSYN interrupt pulse, and flags FIFO overruns.

## Interface
Parameters: none (word width fixed at 16, byte width fixed at 8).
- clk  in  1  bus clock
- reset_n  in  1  asynchronous, active-low reset
- clk7_en  in  1  clock enable; all registers update only on clk edges with clk7_en=1
- bit_valid  in  1  one MFM bit present on bit_in this enabled cycle
- bit_in  in  1  MFM data bit, MSB-first order
- dma_en  in  1  disk read DMA enabled (DSKLEN DMAEN, read direction)
- wordsync_en  in  1  ADKCON WORDSYNC
- dsksync  in  16  sync pattern (DSKSYNC register)
- fifo_full  in  1  full flag from the floppy FIFO
- fifo_data  out  16  assembled word to the FIFO `in` port
- fifo_wr  out  1  FIFO write strobe, high for exactly one enabled cycle per word
- sync_det  out  1  DSKSYN pulse, one enabled cycle
- overflow  out  1  sticky: a completed word was dropped because fifo_full=1
- byte_data  out  8  last completed byte (DSKBYTR[7:0])
- byte_ready  out  1  pulse, one enabled cycle, per completed byte

## Operation
- Shift register sr[15:0]: on bit_valid, sr <= {sr[14:0], bit_in}. It shifts in every state. nsr denotes the post-shift value.
- Bit counter bcnt[3:0]: increments mod 16 on each bit_valid.
- Sync match: bit_valid and nsr == dsksync.
  - On a match, sync_det pulses regardless of state or wordsync_en.
  - If wordsync_en=1, a match also forces bcnt to 0, so the next bit starts a new word. This realigns both word and byte boundaries.
- Byte path: when a bit_valid makes bcnt[2:0] reach 7, or a sync match forces realignment, byte_data <= nsr[7:0] and byte_ready pulses. This runs in all states.
- FSM states: IDLE, HUNT, ASSEMBLE.
  - Any state with dma_en=0: go to IDLE. Any partial word is discarded and no write occurs.
  - IDLE with dma_en=1: go to HUNT if wordsync_en=1, otherwise go to ASSEMBLE with bcnt forced to 0 (bits counted from the next bit_valid).
  - HUNT: no writes. On a sync match, go to ASSEMBLE. The sync word itself is not written.
  - ASSEMBLE: when a bit_valid completes a word (bcnt was 15), present fifo_data <= nsr.
    - If fifo_full=0, pulse fifo_wr.
    - If fifo_full=1, drop the word and set overflow.
  - ASSEMBLE with wordsync_en=1 and a sync match: the sync word is written as a word (bcnt forced to 0), and the state remains ASSEMBLE.
- overflow clears on reset_n=0 or on the cycle dma_en is sampled 0.

## Timing
- Reset values:
  - fifo_data=0, fifo_wr=0, sync_det=0, overflow=0, byte_data=0, byte_ready=0
  - sr=0, bcnt=0, state=IDLE
- All outputs are registered. Latency: one enabled cycle from the completing bit_valid to fifo_wr, sync_det or byte_ready being high.
- Pulses last exactly one enabled cycle. The FIFO samples wr on clk7_en, so one write occurs per word.
- fifo_full is sampled in the same enabled cycle as the completing bit.
- Simultaneous events:
  - dma_en=0 together with a completing bit: no write; sync_det and byte_ready still fire.
  - Sync match and bcnt=15 in ASSEMBLE: a single write of nsr.
- Back-to-back bit_valid on consecutive enabled cycles is supported at full rate.
- reset_n asserted mid-word: everything returns to reset values immediately (asynchronously). A partial word is never written.

## Test plan
- wordsync_en=1, dsksync=0x4489, dma_en=1; stream 0x4489, 0xAAAA, 0x5555 -> sync_det once after bit 16; fifo_wr twice with 0xAAAA then 0x5555; no write of 0x4489.
- wordsync_en=0, dma_en=1; stream 0x1234, 0xFEDC -> two writes 0x1234, 0xFEDC; byte_ready four times with 0x12, 0x34, 0xFE, 0xDC.
- ASSEMBLE, fifo_full=1 at the 16th bit of 0xBEEF -> no fifo_wr, overflow=1 stays high; dropping dma_en clears it.
- Stream 0xFF in HUNT, then 0x4489 misaligned by 3 bits -> sync_det and realignment; the next 16 bits written as one word.
- dma_en dropped after 10 bits of a word -> IDLE, no write. Re-enable with wordsync_en=0 -> the next word is counted from the first new bit.
- reset_n pulsed low mid-word (asynchronous, between clk edges) -> all outputs 0 immediately; after release, the first write occurs only after 16 new bits.
